axil_arbiter_wr: RTL and testbench



---
 rtl/axil_arbiter_wr.sv | 133 +++++++++++++
 tb/tb_axil_arbiter_wr.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axil_arbiter_wr.sv
// AXI-Lite write-path arbiter: per-slave round-robin grant held from arbitration until that
// slave's B handshake, published as registered one-hot and binary vectors in both orientations.
module axil_arbiter_wr #(
    parameter int unsigned NUMBER_MASTER  = 2,
    parameter int unsigned NUMBER_SLAVE   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned ADDR_SEL_LSB   = 28,
    localparam int unsigned MW = $clog2(NUMBER_MASTER),
    localparam int unsigned SW = $clog2(NUMBER_SLAVE)
) (
    input  logic                                           aclk,
    input  logic                                           aresetn,
    input  logic [NUMBER_MASTER-1:0][AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
    input  logic [NUMBER_MASTER-1:0]                       m_axil_awvalid,
    input  logic [NUMBER_SLAVE-1:0]                        s_axil_bvalid,
    input  logic [NUMBER_SLAVE-1:0]                        s_axil_bready,
    output logic [NUMBER_SLAVE-1:0][NUMBER_MASTER-1:0]     grant_wr,
    output logic [NUMBER_MASTER-1:0][NUMBER_SLAVE-1:0]     grant_wr_trans,
    output logic [NUMBER_SLAVE-1:0][MW-1:0]                grant_wr_cdr,
    output logic [NUMBER_MASTER-1:0][SW-1:0]               grant_wr_cdr_trans
);

    localparam int unsigned CW = MW + 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                                       state_q [NUMBER_SLAVE];
    logic   [NUMBER_SLAVE-1:0][MW-1:0]            rr_ptr_q;

    logic   [NUMBER_MASTER-1:0][SW-1:0]           dec;
    logic   [NUMBER_MASTER-1:0]                   busy_m;
    logic   [NUMBER_SLAVE-1:0][NUMBER_MASTER-1:0] req;
    logic   [NUMBER_SLAVE-1:0]                    win_valid;
    logic   [NUMBER_SLAVE-1:0][MW-1:0]            win_idx;
    logic   [NUMBER_SLAVE-1:0][MW-1:0]            rr_next;

    // Only the slave-select field of each address is consumed.
    logic unused_awaddr;
    assign unused_awaddr = ^m_axil_awaddr;

    always_comb begin
        for (int m = 0; m < NUMBER_MASTER; m++) begin
            dec[m]    = m_axil_awaddr[m][ADDR_SEL_LSB +: SW];
            busy_m[m] = |grant_wr_trans[m];
        end
    end

    // A master already holding a grant is masked so it never owns two slaves at once.
    always_comb begin
        for (int s = 0; s < NUMBER_SLAVE; s++) begin
            for (int m = 0; m < NUMBER_MASTER; m++) begin
                req[s][m] = m_axil_awvalid[m] & (dec[m] == SW'(s)) & ~busy_m[m];
            end
        end
    end

    always_comb begin
        logic [CW-1:0] cand;
        cand      = '0;
        win_valid = '0;
        win_idx   = '0;
        for (int s = 0; s < NUMBER_SLAVE; s++) begin
            for (int i = 0; i < NUMBER_MASTER; i++) begin
                cand = {1'b0, rr_ptr_q[s]} + CW'(i);
                if (cand >= CW'(NUMBER_MASTER)) begin
                    cand = cand - CW'(NUMBER_MASTER);
                end
                if (!win_valid[s] && req[s][cand[MW-1:0]]) begin
                    win_valid[s] = 1'b1;
                    win_idx[s]   = cand[MW-1:0];
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NUMBER_SLAVE; s++) begin
            if (win_idx[s] == MW'(NUMBER_MASTER - 1)) begin
                rr_next[s] = '0;
            end else begin
                rr_next[s] = win_idx[s] + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int s = 0; s < NUMBER_SLAVE; s++) begin
                state_q[s] <= StIdle;
            end
            rr_ptr_q           <= '0;
            grant_wr           <= '0;
            grant_wr_trans     <= '0;
            grant_wr_cdr       <= '0;
            grant_wr_cdr_trans <= '0;
        end else begin
            for (int s = 0; s < NUMBER_SLAVE; s++) begin
                case (state_q[s])
                    StIdle: begin
                        if (win_valid[s]) begin
                            state_q[s]      <= StBusy;
                            rr_ptr_q[s]     <= rr_next[s];
                            grant_wr_cdr[s] <= win_idx[s];
                            for (int m = 0; m < NUMBER_MASTER; m++) begin
                                grant_wr[s][m]       <= (win_idx[s] == MW'(m));
                                grant_wr_trans[m][s] <= (win_idx[s] == MW'(m));
                                if (win_idx[s] == MW'(m)) begin
                                    grant_wr_cdr_trans[m] <= SW'(s);
                                end
                            end
                        end
                    end
                    StBusy: begin
                        // Grant is frozen here; only the B handshake ends it.
                        if (s_axil_bvalid[s] && s_axil_bready[s]) begin
                            state_q[s]      <= StIdle;
                            grant_wr[s]     <= '0;
                            grant_wr_cdr[s] <= '0;
                            for (int m = 0; m < NUMBER_MASTER; m++) begin
                                grant_wr_trans[m][s] <= 1'b0;
                                if (grant_wr[s][m]) begin
                                    grant_wr_cdr_trans[m] <= '0;
                                end
                            end
                        end
                    end
                    default: state_q[s] <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axil_arbiter_wr.sv
// Bench for axil_arbiter_wr: directed scenarios then random traffic, checked each cycle
// against a per-slave owner/pointer model.
module tb_axil_arbiter_wr;

    localparam int NM  = 2;
    localparam int NS  = 4;
    localparam int AW  = 32;
    localparam int LSB = 28;
    localparam int MW  = 1;
    localparam int SW  = 2;

    logic                    aclk = 1'b0;
    logic                    aresetn;
    logic [NM-1:0][AW-1:0]   awaddr;
    logic [NM-1:0]           awvalid;
    logic [NS-1:0]           bvalid;
    logic [NS-1:0]           bready;
    logic [NS-1:0][NM-1:0]   grant_wr;
    logic [NM-1:0][NS-1:0]   grant_wr_trans;
    logic [NS-1:0][MW-1:0]   grant_wr_cdr;
    logic [NM-1:0][SW-1:0]   grant_wr_cdr_trans;

    int owner [NS];
    int ptr   [NS];
    int vectors     = 0;
    int miscompares = 0;

    axil_arbiter_wr #(
        .NUMBER_MASTER  (NM),
        .NUMBER_SLAVE   (NS),
        .AXI_ADDR_WIDTH (AW),
        .ADDR_SEL_LSB   (LSB)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .m_axil_awaddr      (awaddr),
        .m_axil_awvalid     (awvalid),
        .s_axil_bvalid      (bvalid),
        .s_axil_bready      (bready),
        .grant_wr           (grant_wr),
        .grant_wr_trans     (grant_wr_trans),
        .grant_wr_cdr       (grant_wr_cdr),
        .grant_wr_cdr_trans (grant_wr_cdr_trans)
    );

    always #5 aclk = ~aclk;

    function automatic int dec_of(logic [AW-1:0] a);
        return int'(a[LSB +: SW]);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            owner[s] = -1;
            ptr[s]   = 0;
        end
    endtask

    // One rising edge: release on B handshake, else round-robin among unbusy requesters.
    task automatic model_edge();
        int nowner [NS];
        bit busy [NM];
        for (int m = 0; m < NM; m++) busy[m] = 1'b0;
        for (int s = 0; s < NS; s++) if (owner[s] >= 0) busy[owner[s]] = 1'b1;
        for (int s = 0; s < NS; s++) begin
            nowner[s] = owner[s];
            if (owner[s] >= 0) begin
                if (bvalid[s] && bready[s]) nowner[s] = -1;
            end else begin
                for (int i = 0; i < NM; i++) begin
                    int m;
                    m = (ptr[s] + i) % NM;
                    if (nowner[s] < 0 && awvalid[m] && dec_of(awaddr[m]) == s && !busy[m]) begin
                        nowner[s] = m;
                        ptr[s]    = (m + 1) % NM;
                    end
                end
            end
        end
        for (int s = 0; s < NS; s++) owner[s] = nowner[s];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NS-1:0][NM-1:0] eg;
        logic [NM-1:0][NS-1:0] et;
        logic [NS-1:0][MW-1:0] ec;
        logic [NM-1:0][SW-1:0] ect;
        eg = '0; et = '0; ec = '0; ect = '0;
        for (int s = 0; s < NS; s++) begin
            if (owner[s] >= 0) begin
                eg[s][owner[s]] = 1'b1;
                et[owner[s]][s] = 1'b1;
                ec[s]           = MW'(owner[s]);
                ect[owner[s]]   = SW'(s);
            end
        end
        chk({tag, ".grant_wr"}, 32'(grant_wr), 32'(eg));
        chk({tag, ".grant_wr_trans"}, 32'(grant_wr_trans), 32'(et));
        chk({tag, ".grant_wr_cdr"}, 32'(grant_wr_cdr), 32'(ec));
        chk({tag, ".grant_wr_cdr_trans"}, 32'(grant_wr_cdr_trans), 32'(ect));
    endtask

    task automatic tick(input string tag);
        @(posedge aclk);
        if (aresetn) model_edge();
        else model_reset();
        #1;
        check_all(tag);
    endtask

    task automatic set_m(input int m, input logic v, input int slave);
        logic [AW-1:0] a;
        a = $urandom;
        a[LSB +: SW] = SW'(slave);
        awaddr[m]  = a;
        awvalid[m] = v;
    endtask

    // Called just after a sampling edge, so the low pulse lands mid-cycle.
    task automatic apply_reset(input string tag);
        aresetn = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".async"});
        tick({tag, ".held"});
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0;
        awvalid = '0;
        awaddr  = '0;
        bvalid  = '0;
        bready  = '0;
        model_reset();

        // Reset held with requests pending; M0 -> slave 0, M1 -> slave 3.
        set_m(0, 1'b1, 0);
        set_m(1, 1'b1, 3);
        #1;
        check_all("rst0");
        repeat (3) tick("rst_hold");
        aresetn = 1'b1;
        tick("rst_first");
        chk("par_g0", 32'(grant_wr[0]), 32'h1);
        chk("par_g3", 32'(grant_wr[3]), 32'h2);
        awvalid = '0;
        bvalid[0] = 1'b1; bready[0] = 1'b1;
        tick("par_rel0");
        chk("par_g3_hold", 32'(grant_wr[3]), 32'h2);
        bvalid = '0; bready = '0;
        bvalid[3] = 1'b1; bready[3] = 1'b1;
        tick("par_rel3");
        bvalid = '0; bready = '0;

        // Single transfer, M1 to 0x2000_0000.
        apply_reset("rst_single");
        awaddr[1] = 32'h2000_0000; awvalid[1] = 1'b1;
        tick("single_grant");
        chk("single_g2", 32'(grant_wr[2]), 32'h2);
        chk("single_cdr2", 32'(grant_wr_cdr[2]), 32'h1);
        chk("single_t1", 32'(grant_wr_trans[1]), 32'h4);
        chk("single_ct1", 32'(grant_wr_cdr_trans[1]), 32'h2);
        awvalid[1] = 1'b0;
        repeat (3) tick("single_hold");
        bvalid[2] = 1'b1; bready[2] = 1'b1;
        tick("single_rel");
        chk("single_clr", 32'(grant_wr[2]), 32'h0);
        bvalid = '0; bready = '0;

        // Contention on slave 1: M0, M1, M0, M1.
        apply_reset("rst_rr");
        awaddr[0] = 32'h1000_0000; awaddr[1] = 32'h1abc_0004;
        awvalid = '1;
        for (int t = 0; t < 4; t++) begin
            tick("rr_grant");
            chk("rr_order", 32'(grant_wr[1]), 32'(1 << (t % 2)));
            bvalid[1] = 1'b1; bready[1] = 1'b1;
            tick("rr_rel");
            bvalid = '0; bready = '0;
        end
        awvalid = '0;

        // Busy mask: M0 holds slave 0 while retargeting to slave 2.
        apply_reset("rst_busy");
        set_m(0, 1'b1, 0);
        tick("busy_g0");
        set_m(0, 1'b1, 2);
        repeat (2) begin
            tick("busy_wait");
            chk("busy_no_g2", 32'(grant_wr[2]), 32'h0);
        end
        bvalid[0] = 1'b1; bready[0] = 1'b1;
        tick("busy_rel");
        chk("busy_masked", 32'(grant_wr[2]), 32'h0);
        bvalid = '0; bready = '0;
        tick("busy_g2");
        chk("busy_g2_m0", 32'(grant_wr[2]), 32'h1);

        // Async reset mid-busy, well before the next edge.
        #2;
        aresetn = 1'b0;
        model_reset();
        #1;
        chk("areset_g", 32'(grant_wr), 32'h0);
        check_all("areset_all");
        awvalid = '0;
        tick("areset_held");
        aresetn = 1'b1;
        tick("areset_idle");

        // Random traffic including stray B handshakes on idle slaves.
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < NM; m++) begin
                set_m(m, 1'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)));
            end
            for (int s = 0; s < NS; s++) begin
                bvalid[s] = ($urandom_range(0, 3) == 0);
                bready[s] = ($urandom_range(0, 1) == 0);
            end
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
